// File: rtl/robot_cmd_sequencer.sv
// Drive-command sequencer: streams per-segment UART packets, holds each segment for a tick count,
// loops passes, then finishes. Define ROBOT_CMD_SEQUENCER_STOP_PACKET_EN to emit a stop packet.
module robot_cmd_sequencer #(
  parameter int         NUM_SEGS      = 4,
  parameter int         BYTES_PER_SEG = 5,
  parameter int         DUR_W         = 16,
  parameter int         LOOPS         = 1,
  parameter logic [7:0] STOP_OPCODE   = 8'd137
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              go,
  input  logic                              abort,
  input  logic                              tick,
  input  logic [NUM_SEGS*BYTES_PER_SEG*8-1:0] seg_bytes,
  input  logic [NUM_SEGS*DUR_W-1:0]         seg_dur,
  input  logic                              tx_full,
  output logic [7:0]                        tx_data,
  output logic                              tx_write,
  output logic                              busy,
  output logic                              done,
  output logic [3:0]                        seg_idx
);

  typedef enum logic [2:0] {IDLE, SEND, HOLD, STOP, FINISH} state_t;

  localparam logic [2:0] LAST_B = 3'(BYTES_PER_SEG - 1);
  localparam logic [3:0] LAST_S = 4'(NUM_SEGS - 1);

  state_t           state;
  logic [2:0]       byte_idx;
  logic [15:0]      pass_cnt;
  logic [15:0]      pass_nxt;
  logic [DUR_W-1:0] hold_cnt;
  logic             abort_pend;
  logic [7:0]       tx_last;
  logic [7:0]       cur_byte;
  logic             last_byte;
  logic             pass_more;
  logic             emit;

  always_comb begin
    cur_byte = seg_bytes[(int'(seg_idx) * BYTES_PER_SEG + int'(byte_idx)) * 8 +: 8];
    if (state == STOP) cur_byte = (byte_idx == 3'd0) ? STOP_OPCODE : 8'h00;
  end

`ifdef ROBOT_CMD_SEQUENCER_STOP_PACKET_EN
  assign emit = (state == SEND) || (state == STOP);
`else
  assign emit = (state == SEND);
`endif

  // Write strobe follows tx_full in the same cycle so a full buffer stalls without loss.
  assign tx_write  = emit && !tx_full && !rst;
  assign tx_data   = tx_write ? cur_byte : tx_last;
  assign last_byte = (byte_idx == LAST_B);
  assign pass_nxt  = (pass_cnt == 16'hFFFF) ? pass_cnt : pass_cnt + 16'd1;
  assign pass_more = (LOOPS == 0) || (int'(pass_nxt) < LOOPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_idx   <= '0;
      seg_idx    <= '0;
      pass_cnt   <= '0;
      hold_cnt   <= '0;
      abort_pend <= 1'b0;
      tx_last    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (tx_write) tx_last <= cur_byte;
      unique case (state)
        IDLE: if (go && !abort) begin
          state      <= SEND;
          busy       <= 1'b1;
          seg_idx    <= '0;
          byte_idx   <= '0;
          pass_cnt   <= '0;
          abort_pend <= 1'b0;
        end
        SEND: begin
          if (abort) abort_pend <= 1'b1;
          if (tx_write) begin
            if (last_byte) begin
              byte_idx <= '0;
              if (abort || abort_pend) begin
                state      <= STOP;
                abort_pend <= 1'b0;
              end else begin
                state    <= HOLD;
                hold_cnt <= seg_dur[int'(seg_idx) * DUR_W +: DUR_W];
              end
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end
        end
        HOLD: begin
          if (abort) begin
            state <= STOP;
          end else if (hold_cnt == '0) begin
            if (seg_idx != LAST_S) begin
              seg_idx <= seg_idx + 4'd1;
              state   <= SEND;
            end else begin
              pass_cnt <= pass_nxt;
              if (pass_more) begin
                seg_idx <= '0;
                state   <= SEND;
              end else begin
                state <= STOP;
              end
            end
          end else if (tick) begin
            hold_cnt <= hold_cnt - DUR_W'(1);
          end
        end
        STOP: begin
`ifdef ROBOT_CMD_SEQUENCER_STOP_PACKET_EN
          if (tx_write) begin
            if (last_byte) begin
              byte_idx <= '0;
              state    <= FINISH;
              done     <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end
`else
          state <= FINISH;
          done  <= 1'b1;
`endif
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_robot_cmd_sequencer.sv
// Bench for robot_cmd_sequencer: queue-based packet/timing model checked every cycle,
// directed scenarios with literal expectations, randomized runs, and a LOOPS=2 instance.
module tb_robot_cmd_sequencer;
  localparam int NS = 4;
  localparam int BP = 5;
  localparam int DW = 16;
`ifdef ROBOT_CMD_SEQUENCER_STOP_PACKET_EN
  localparam int STOP_EN = 1;
`else
  localparam int STOP_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst, go, abort, tick, tx_full;
  logic [NS*BP*8-1:0] seg_bytes;
  logic [NS*DW-1:0]   seg_dur;
  logic [7:0] tx_data, tx_data2;
  logic       tx_write, busy, done, tx_write2, busy2, done2;
  logic [3:0] seg_idx, seg_idx2;

  always #5 clk = ~clk;

  robot_cmd_sequencer dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort), .tick(tick),
    .seg_bytes(seg_bytes), .seg_dur(seg_dur), .tx_full(tx_full),
    .tx_data(tx_data), .tx_write(tx_write), .busy(busy), .done(done), .seg_idx(seg_idx));

  robot_cmd_sequencer #(.LOOPS(2)) dut2 (
    .clk(clk), .rst(rst), .go(go), .abort(abort), .tick(tick),
    .seg_bytes(seg_bytes), .seg_dur(seg_dur), .tx_full(tx_full),
    .tx_data(tx_data2), .tx_write(tx_write2), .busy(busy2), .done(done2), .seg_idx(seg_idx2));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {K_SEG, K_STOP, K_DONE} kind_t;
  typedef struct {
    kind_t      kind;
    logic [7:0] val;
    int         seg;
    bit         last;
    int         gate;   // ticks to hold before this entry, -1 = none
    int         delay;  // extra cycles before eligible
  } ent_t;

  ent_t       q[$];
  bit         m_active = 0, m_hold = 0;
  int         m_rem = 0, m_ready = 0, go_cyc = 0;
  logic [7:0] m_last = 8'h00;

  logic [7:0] wlog[$];
  int         wcyc[$];
  int         done_cnt = 0, done_cyc = 0;
  logic [7:0] w2[$];
  int         done2_cnt = 0;

  function automatic int dur_of(input int s);
    return int'(seg_dur[s*DW +: DW]);
  endfunction

  function automatic void append_tail(input int g);
    ent_t e;
    if (STOP_EN != 0) begin
      for (int b = 0; b < BP; b++) begin
        e.kind = K_STOP; e.val = (b == 0) ? 8'd137 : 8'd0; e.seg = -1;
        e.last = (b == BP-1); e.gate = (b == 0) ? g : -1; e.delay = 0;
        q.push_back(e);
      end
      e.kind = K_DONE; e.val = 8'd0; e.seg = -1; e.last = 1'b0; e.gate = -1; e.delay = 0;
      q.push_back(e);
    end else begin
      e.kind = K_DONE; e.val = 8'd0; e.seg = -1; e.last = 1'b0; e.gate = g; e.delay = 1;
      q.push_back(e);
    end
  endfunction

  function automatic void build();
    ent_t e;
    q.delete();
    for (int s = 0; s < NS; s++)
      for (int b = 0; b < BP; b++) begin
        e.kind = K_SEG; e.val = seg_bytes[(s*BP+b)*8 +: 8]; e.seg = s;
        e.last = (b == BP-1); e.gate = (b == 0 && s > 0) ? dur_of(s-1) : -1; e.delay = 0;
        q.push_back(e);
      end
    append_tail(dur_of(NS-1));
  endfunction

  // Abort while sending: finish the packet on the wire, then the stop tail.
  function automatic void truncate();
    int k = 0;
    while (k < q.size() && !q[k].last) k++;
    while (q.size() > k+1) void'(q.pop_back());
    append_tail(-1);
  endfunction

  always @(negedge clk) begin
    bit elig, ew, ed;
    if (rst) begin
      check("tx_write_in_rst", tx_write, 0);
      q.delete(); m_active = 0; m_hold = 0; m_last = 8'h00;
    end else begin
      elig = m_active && !m_hold && (m_ready <= cyc) && (q.size() > 0);
      ew   = elig && (q[0].kind != K_DONE) && !tx_full;
      ed   = elig && (q[0].kind == K_DONE);
      check("tx_write", tx_write, ew);
      check("done", done, ed);
      check("busy", busy, m_active);
      if (ew) begin
        check("tx_data", tx_data, q[0].val);
        if (q[0].kind == K_SEG) check("seg_idx", seg_idx, q[0].seg);
        m_last = q[0].val;
      end else begin
        check("tx_data_hold", tx_data, m_last);
      end
      if (tx_write) begin wlog.push_back(tx_data); wcyc.push_back(cyc); end
      if (done) begin done_cnt++; done_cyc = cyc; end

      if (!m_active) begin
        if (go && !abort) begin
          build(); m_active = 1; m_hold = 0; m_ready = cyc + 1; go_cyc = cyc;
        end
      end else begin
        if (abort) begin
          if (m_hold) begin
            q.delete(); append_tail(-1); m_hold = 0; m_ready = cyc + 1 + q[0].delay;
          end else if (elig && q[0].kind == K_SEG) begin
            truncate();
          end
        end else if (m_hold) begin
          if (m_rem == 0) begin m_hold = 0; m_ready = cyc + 1 + q[0].delay; end
          else if (tick) m_rem--;
        end
        if (ed) begin
          void'(q.pop_front()); m_active = 0;
        end else if (ew) begin
          void'(q.pop_front());
          if (q.size() > 0) begin
            if (q[0].gate >= 0) begin m_hold = 1; m_rem = q[0].gate; end
            else m_ready = cyc + 1 + q[0].delay;
          end
        end
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    if (tx_write2) w2.push_back(tx_data2);
    if (done2) done2_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_go();
    go = 1'b1; step(); go = 1'b0;
  endtask

  task automatic clear_logs();
    wlog.delete(); wcyc.delete(); done_cnt = 0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (m_active && n < bound) begin step(); n++; end
    if (m_active) fail_timeout(name);
    repeat (3) step();
  endtask

  task automatic set_pattern();
    for (int s = 0; s < NS; s++)
      for (int b = 0; b < BP; b++) seg_bytes[(s*BP+b)*8 +: 8] = 8'(s*16 + b + 1);
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i / BP) * 16 + (i % BP) + 1);
  endfunction

  task automatic seq_check(input string name, input int nbytes);
    int bad = 0;
    for (int i = 0; i < nbytes; i++) if (wlog[i] !== pat(i)) bad++;
    check(name, bad, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; go = 1'b0; abort = 1'b0; tick = 1'b0; tx_full = 1'b0;
    set_pattern();
    seg_dur = {16'd1, 16'd2, 16'd0, 16'd3};
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_seg_idx", seg_idx, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_write", tx_write, 0);

    // Nominal run, durations {3,0,2,1}, tick every cycle.
    tick = 1'b1;
    clear_logs();
    pulse_go();
    wait_idle("nominal", 300);
    check("nom_bytes", wlog.size(), 20 + BP*STOP_EN);
    seq_check("nom_seq", 20);
    check("nom_first_lat", wcyc[0] - go_cyc, 1);
    check("nom_seg1_start", wcyc[5] - go_cyc, 10);
    check("nom_seg1_byte0", wlog[5], 8'h11);
    check("nom_done_cnt", done_cnt, 1);
    check("nom_done_cyc", done_cyc - go_cyc, (STOP_EN != 0) ? 36 : 32);

    // tx_full stall mid-packet.
    clear_logs();
    pulse_go();
    n = 0;
    while (wlog.size() < 2 && n < 50) begin step(); n++; end
    if (wlog.size() < 2) fail_timeout("stall_start");
    tx_full = 1'b1;
    n = wlog.size();
    repeat (5) step();
    check("stall_no_write", wlog.size(), n);
    tx_full = 1'b0;
    wait_idle("stall", 300);
    check("stall_bytes", wlog.size(), 20 + BP*STOP_EN);
    seq_check("stall_seq", 20);

    // Abort on third byte of segment 2.
    clear_logs();
    pulse_go();
    n = 0;
    while (!(wlog.size() == 12 && tx_write) && n < 100) begin step(); n++; end
    if (n >= 100) fail_timeout("abort_wait");
    abort = 1'b1; step(); abort = 1'b0;
    wait_idle("abort", 300);
    check("abort_bytes", wlog.size(), 15 + BP*STOP_EN);
    seq_check("abort_seq", 15);
    check("abort_done_cnt", done_cnt, 1);
    check("abort_busy", busy, 0);

    // Reset during the hold of segment 1.
    tick = 1'b0;
    seg_dur = {16'd0, 16'd0, 16'd5, 16'd0};
    clear_logs();
    pulse_go();
    n = 0;
    while (wlog.size() < 10 && n < 100) begin step(); n++; end
    if (wlog.size() < 10) fail_timeout("rst_hold_wait");
    repeat (3) step();
    rst = 1'b1; step(); rst = 1'b0;
    check("rsthold_busy", busy, 0);
    check("rsthold_seg_idx", seg_idx, 0);
    check("rsthold_done", done, 0);
    repeat (20) step();
    check("rsthold_no_tx", wlog.size(), 10);
    check("rsthold_no_done", done_cnt, 0);

    // Randomized runs.
    for (int it = 0; it < 10; it++) begin
      for (int w = 0; w < NS*BP*8/32; w++) seg_bytes[w*32 +: 32] = $urandom();
      for (int s = 0; s < NS; s++) seg_dur[s*DW +: DW] = DW'($urandom_range(0, 3));
      abort = ($urandom_range(0, 5) == 0);
      pulse_go();
      abort = 1'b0;
      n = 0;
      while (m_active && n < 3000) begin
        tx_full = ($urandom_range(0, 3) == 0);
        tick    = $urandom_range(0, 1);
        abort   = (it % 2 == 1) && ($urandom_range(0, 29) == 0);
        go      = ($urandom_range(0, 19) == 0);
        step();
        n++;
      end
      go = 1'b0; abort = 1'b0; tx_full = 1'b0; tick = 1'b0;
      if (m_active) fail_timeout("random_run");
      repeat (5) step();
    end

    // LOOPS=2 instance: two passes, one stop packet, one done.
    rst = 1'b1; repeat (2) step(); rst = 1'b0;
    set_pattern();
    seg_dur = {16'd0, 16'd1, 16'd0, 16'd1};
    tick = 1'b1;
    w2.delete(); done2_cnt = 0;
    pulse_go();
    n = 0;
    while (done2_cnt == 0 && n < 500) begin step(); n++; end
    if (done2_cnt == 0) fail_timeout("loops2");
    repeat (5) step();
    check("loops2_bytes", w2.size(), 40 + BP*STOP_EN);
    n = 0;
    for (int i = 0; i < 40; i++) if (w2[i] !== pat(i % 20)) n++;
    check("loops2_seq", n, 0);
    check("loops2_done_cnt", done2_cnt, 1);
    check("loops2_busy", busy2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
